// File: rtl/lsu_ctrl_if.sv
// ---------------------------------------------------------------------------
// lsu_ctrl_if -- bundle of every lsu_ctrl signal except the clock and reset.
//
// Also defines the 4-bit memory operation codes (`LB .. `NONE) shared by the
// controller and anything that drives it.
//
// Modports:
//   slave  : the load/store controller. It takes requests from exe_mem, drives
//            the RAM request channel, and drives writeback and exceptions.
//   master : the environment. It is the pipeline plus the RAM: it drives
//            requests and RAM responses, and observes everything else.
//
// Signals (pipeline side):
//   req_i, mem_op_i[3:0], mem_addr_i, mem_data_i, reg_waddr_i[4:0], stall_o
// Signals (RAM side):
//   ram_req_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o,
//   ram_rdata_i, ram_ack_i
// Signals (writeback / trap side):
//   reg_we_o, reg_waddr_o, reg_wdata_o, exc_valid_o, exc_cause_o, exc_tval_o
// ---------------------------------------------------------------------------
`ifndef LSU_CTRL_OPCODES
`define LSU_CTRL_OPCODES
`define LB   4'h0
`define LH   4'h1
`define LW   4'h2
`define LD   4'h3
`define LBU  4'h4
`define LHU  4'h5
`define LWU  4'h6
`define SB   4'h8
`define SH   4'h9
`define SW   4'hA
`define SD   4'hB
`define NONE 4'hF
`endif

interface lsu_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) ();
  logic                    req_i;
  logic [3:0]              mem_op_i;
  logic [ADDR_WIDTH-1:0]   mem_addr_i;
  logic [DATA_WIDTH-1:0]   mem_data_i;
  logic [4:0]              reg_waddr_i;
  logic                    stall_o;

  logic                    ram_req_o;
  logic                    ram_we_o;
  logic [DATA_WIDTH/8-1:0] ram_be_o;
  logic [ADDR_WIDTH-1:0]   ram_addr_o;
  logic [DATA_WIDTH-1:0]   ram_wdata_o;
  logic [DATA_WIDTH-1:0]   ram_rdata_i;
  logic                    ram_ack_i;

  logic                    reg_we_o;
  logic [4:0]              reg_waddr_o;
  logic [DATA_WIDTH-1:0]   reg_wdata_o;
  logic                    exc_valid_o;
  logic [31:0]             exc_cause_o;
  logic [ADDR_WIDTH-1:0]   exc_tval_o;

  modport slave (
    input  req_i, mem_op_i, mem_addr_i, mem_data_i, reg_waddr_i,
    output stall_o,
    output ram_req_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o,
    input  ram_rdata_i, ram_ack_i,
    output reg_we_o, reg_waddr_o, reg_wdata_o,
    output exc_valid_o, exc_cause_o, exc_tval_o
  );

  modport master (
    output req_i, mem_op_i, mem_addr_i, mem_data_i, reg_waddr_i,
    input  stall_o,
    input  ram_req_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o,
    output ram_rdata_i, ram_ack_i,
    input  reg_we_o, reg_waddr_o, reg_wdata_o,
    input  exc_valid_o, exc_cause_o, exc_tval_o
  );
endinterface

// File: rtl/lsu_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_ctrl -- single-outstanding load/store controller between exe_mem and a
// word-wide RAM.
//
// Each accepted request is handled in three steps:
//   - It is aligned.
//   - It is issued to the RAM, with byte enables and lane-positioned data.
//   - A load result is extracted and extended for writeback, or a trap is
//     raised instead.
//
// The FSM has three states:
//   IDLE : accept a request
//   BUSY : RAM request outstanding
//   RESP : one-cycle writeback or exception
//
// Ports:
//   clk_i : clock
//   rst_i : asynchronous active-high reset; forces IDLE and zero outputs
//   bus   : lsu_ctrl_if.slave
//           - pipeline request and stall
//           - RAM channel
//           - register writeback
//           - exception (mcause / mtval)
//
// Parameters:
//   DATA_WIDTH     : 32 or 64, data path and RAM word width
//   ADDR_WIDTH     : byte address width (at least 3)
//   TIMEOUT_CYCLES : BUSY cycle limit, used only when LSU_TIMEOUT_EN is set
//
// Build option:
//   LSU_TIMEOUT_EN : when defined, a BUSY cycle counter aborts an unanswered
//                    RAM request. The trap cause is 5 for a load and 7 for a
//                    store. When undefined, BUSY waits for ram_ack_i forever.
// ---------------------------------------------------------------------------
module lsu_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  lsu_ctrl_if.slave   bus
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BE_W);

  if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64) || TIMEOUT_CYCLES < 1 || ADDR_WIDTH < 3)
  begin : g_param_check
    $error("lsu_ctrl: unsupported parameter combination");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  // ---------------------------------------------------------------- decode
  function automatic logic op_known(input logic [3:0] op);
    case (op)
      `LB, `LH, `LW, `LD, `LBU, `LHU, `LWU, `SB, `SH, `SW, `SD: op_known = 1'b1;
      default:                                                 op_known = 1'b0;
    endcase
  endfunction

  function automatic logic op_store(input logic [3:0] op);
    op_store = (op == `SB) || (op == `SH) || (op == `SW) || (op == `SD);
  endfunction

  // log2 of the access size in bytes
  function automatic logic [1:0] op_size(input logic [3:0] op);
    case (op)
      `LH, `LHU, `SH:      op_size = 2'd1;
      `LW, `LWU, `SW:      op_size = 2'd2;
      `LD, `SD:            op_size = 2'd3;
      default:             op_size = 2'd0;
    endcase
  endfunction

  // Operations that only exist on a 64-bit data path
  function automatic logic op_wide(input logic [3:0] op);
    op_wide = (op == `LD) || (op == `LWU) || (op == `SD);
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] a);
    case (size)
      2'd1:    misaligned = a[0];
      2'd2:    misaligned = |a[1:0];
      2'd3:    misaligned = |a[2:0];
      default: misaligned = 1'b0;
    endcase
  endfunction

  // ----------------------------------------------------------------- state
  state_t                  state_q, state_d;
  logic [3:0]              op_q, op_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [4:0]              waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;
  logic                    exc_q, exc_d;
  logic [2:0]              cause_q, cause_d;
  logic [ADDR_WIDTH-1:0]   tval_q, tval_d;
`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]        cnt_q, cnt_d;
`endif

  // ---------------------------------------------------- datapath helpers
  logic [OFF_W-1:0]        off;
  logic [BE_W-1:0]         be_base;
  logic [DATA_WIDTH-1:0]   lane_data;
  logic [DATA_WIDTH-1:0]   ld_shift;
  logic [DATA_WIDTH-1:0]   ld_ext;

  assign off = addr_q[OFF_W-1:0];

  // Unshifted size mask and the store data trimmed to that size; both are
  // then moved up to the addressed lanes, so untouched lanes carry zero.
  always_comb begin
    be_base = '0;
    case (op_size(op_q))
      2'd0:    be_base[0]   = 1'b1;
      2'd1:    be_base[1:0] = 2'b11;
      2'd2:    be_base[3:0] = 4'hF;
      default: be_base      = '1;
    endcase
    lane_data = '0;
    for (int i = 0; i < BE_W; i++) begin
      if (be_base[i]) lane_data[8*i +: 8] = data_q[8*i +: 8];
    end
  end

  always_comb begin
    ld_shift = bus.ram_rdata_i >> {off, 3'b000};
    ld_ext   = ld_shift;
    case (op_q)
      `LB:  begin ld_ext = {DATA_WIDTH{ld_shift[7]}};  ld_ext[7:0]  = ld_shift[7:0];  end
      `LH:  begin ld_ext = {DATA_WIDTH{ld_shift[15]}}; ld_ext[15:0] = ld_shift[15:0]; end
      `LW:  begin ld_ext = {DATA_WIDTH{ld_shift[31]}}; ld_ext[31:0] = ld_shift[31:0]; end
      `LBU: begin ld_ext = '0; ld_ext[7:0]  = ld_shift[7:0];  end
      `LHU: begin ld_ext = '0; ld_ext[15:0] = ld_shift[15:0]; end
      `LWU: begin ld_ext = '0; ld_ext[31:0] = ld_shift[31:0]; end
      default: ld_ext = ld_shift;
    endcase
  end

  // -------------------------------------------------------- state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      op_q     <= `NONE;
      addr_q   <= '0;
      data_q   <= '0;
      waddr_q  <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      cause_q  <= '0;
      tval_q   <= '0;
`ifdef LSU_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      waddr_q  <= waddr_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      cause_q  <= cause_d;
      tval_q   <= tval_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  // ------------------------------------------------------------ next state
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    data_d   = data_q;
    waddr_d  = waddr_q;
    result_d = result_q;
    exc_d    = exc_q;
    cause_d  = cause_q;
    tval_d   = tval_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req_i && op_known(bus.mem_op_i)) begin
          op_d     = bus.mem_op_i;
          addr_d   = bus.mem_addr_i;
          data_d   = bus.mem_data_i;
          waddr_d  = bus.reg_waddr_i;
          result_d = '0;
          exc_d    = 1'b0;
          cause_d  = '0;
          tval_d   = '0;
`ifdef LSU_TIMEOUT_EN
          cnt_d    = '0;
`endif
          // An unsupported width outranks misalignment and reports mtval=0
          if (DATA_WIDTH == 32 && op_wide(bus.mem_op_i)) begin
            exc_d   = 1'b1;
            cause_d = 3'd2;
            state_d = RESP;
          end else if (misaligned(op_size(bus.mem_op_i), bus.mem_addr_i[2:0])) begin
            exc_d   = 1'b1;
            cause_d = op_store(bus.mem_op_i) ? 3'd6 : 3'd4;
            tval_d  = bus.mem_addr_i;
            state_d = RESP;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (bus.ram_ack_i) begin
          state_d = RESP;
          if (!op_store(op_q)) result_d = ld_ext;
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = RESP;
          exc_d   = 1'b1;
          cause_d = op_store(op_q) ? 3'd7 : 3'd5;
          tval_d  = addr_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------- outputs
  always_comb begin
    bus.stall_o     = 1'b0;
    bus.ram_req_o   = 1'b0;
    bus.ram_we_o    = 1'b0;
    bus.ram_be_o    = '0;
    bus.ram_addr_o  = '0;
    bus.ram_wdata_o = '0;
    bus.reg_we_o    = 1'b0;
    bus.reg_waddr_o = '0;
    bus.reg_wdata_o = '0;
    bus.exc_valid_o = 1'b0;
    bus.exc_cause_o = '0;
    bus.exc_tval_o  = '0;
    case (state_q)
      IDLE: begin
        // Reset also masks the combinational request path
        bus.stall_o = !rst_i && bus.req_i && op_known(bus.mem_op_i);
      end
      BUSY: begin
        bus.stall_o    = 1'b1;
        bus.ram_req_o  = 1'b1;
        bus.ram_we_o   = op_store(op_q);
        bus.ram_be_o   = be_base << off;
        bus.ram_addr_o = {addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
        if (op_store(op_q)) bus.ram_wdata_o = lane_data << {off, 3'b000};
      end
      RESP: begin
        if (exc_q) begin
          bus.exc_valid_o = 1'b1;
          bus.exc_cause_o = {29'd0, cause_q};
          bus.exc_tval_o  = tval_q;
        end else if (!op_store(op_q) && waddr_q != 5'd0) begin
          bus.reg_we_o    = 1'b1;
          bus.reg_waddr_o = waddr_q;
          bus.reg_wdata_o = result_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the data path and RAM word width, legal values 32 or 64.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, meaning the byte address width.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum number of cycles spent in BUSY waiting for ram_ack_i.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-005 The block SHALL have these ports, given as name, direction, width and meaning:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- req_i  in  1  memory op valid from exe_mem.
- mem_op_i  in  4  operation code: `LB `LH `LW `LBU `LHU `SB `SH `SW `LD `LWU `SD `NONE.
- mem_addr_i  in  ADDR_WIDTH  byte address.
- mem_data_i  in  DATA_WIDTH  store data, right-aligned.
- reg_waddr_i  in  5  load destination register.
- stall_o  out  1  hold upstream pipeline.
- ram_req_o  out  1  RAM request valid.
- ram_we_o  out  1  RAM write.
- ram_be_o  out  DATA_WIDTH/8  byte enables.
- ram_addr_o  out  ADDR_WIDTH  word-aligned address.
- ram_wdata_o  out  DATA_WIDTH  lane-positioned write data.
- ram_rdata_i  in  DATA_WIDTH  read data, valid with ram_ack_i.
- ram_ack_i  in  1  RAM completion.
- reg_we_o  out  1  writeback strobe.
- reg_waddr_o  out  5  writeback register.
- reg_wdata_o  out  DATA_WIDTH  extended load result.
- exc_valid_o  out  1  exception pulse.
- exc_cause_o  out  32  mcause value.
- exc_tval_o  out  ADDR_WIDTH  mtval value.

Function
REQ-006 The FSM SHALL have exactly three states, IDLE, BUSY and RESP, with IDLE as the reset state.
REQ-007 In IDLE, req_i=1 with an op other than `NONE SHALL register op, address, data and reg_waddr_i, and then move to BUSY if the access is legal or to RESP with an exception pending if it is not.
REQ-008 In BUSY, ram_req_o SHALL be 1, and ram_addr_o, ram_we_o, ram_be_o and ram_wdata_o SHALL be held stable until the cycle in which ram_ack_i=1.
REQ-009 When ram_ack_i=1 in BUSY, the block SHALL move to RESP; for a load, it SHALL also register the extracted result from ram_rdata_i in that same cycle.
REQ-010 RESP SHALL last one cycle; loads SHALL pulse reg_we_o=1 in RESP unless reg_waddr=0, and stores SHALL leave reg_we_o=0; the FSM SHALL then return to IDLE.
REQ-011 stall_o SHALL be the combinational value (IDLE and req_i and op!=`NONE) or BUSY, and SHALL be 0 in RESP.
REQ-012 Minimum latency SHALL be 2 cycles from req_i to reg_we_o, which occurs when ram_ack_i arrives in the first BUSY cycle.
REQ-013 Alignment SHALL be natural: halfword addr[0]=0, word addr[1:0]=0, doubleword addr[2:0]=0.
REQ-014 A misaligned access SHALL raise no RAM request and SHALL pulse exc_valid_o in RESP, with exc_cause_o=4 for a load or 6 for a store and exc_tval_o=address.
REQ-015 `LD, `LWU and `SD with DATA_WIDTH=32 SHALL raise exc_cause_o=2 with exc_tval_o=0, and SHALL raise no RAM request.
REQ-016 ram_be_o SHALL be the size mask shifted by the address lane offset; ram_wdata_o SHALL place the store data in the selected lanes and drive zero in all other lanes; no read-modify-write SHALL be performed.
REQ-017 The load result SHALL be ram_rdata_i shifted right by 8×offset, then sign-extended (`LB `LH `LW) or zero-extended (`LBU `LHU `LWU) to DATA_WIDTH.
REQ-018 ram_ack_i SHALL be ignored in IDLE and RESP, and req_i SHALL be ignored outside IDLE.
REQ-019 ram_req_o SHALL never be 1 in IDLE or RESP.

Reset
REQ-020 Asserting rst_i SHALL immediately force IDLE, including mid-BUSY, and SHALL drive all outputs to 0, with ram_be_o=0 and exc_cause_o=0.
REQ-021 A RAM response arriving after reset SHALL be discarded.

Configuration
REQ-022 With LSU_TIMEOUT_EN defined, a counter SHALL count BUSY cycles; reaching TIMEOUT_CYCLES without ram_ack_i SHALL drop ram_req_o and move to RESP with exc_cause_o=5 (load) or 7 (store) and exc_tval_o=address.
REQ-023 With LSU_TIMEOUT_EN undefined, no counter SHALL exist and BUSY SHALL wait indefinitely for ram_ack_i.

Verification
REQ-024 DATA_WIDTH=32, `LB at 0x103, ack after 3 cycles with rdata 0x80000000 -> ram_be_o=4'b1000, ram_addr_o=0x100, reg_wdata_o=0xFFFFFF80, and reg_we_o pulses once.
REQ-025 `SH at 0x202 with data 0x1234BEEF -> ram_be_o=4'b1100, ram_wdata_o=0xBEEF0000, ram_we_o=1, and reg_we_o stays 0.
REQ-026 `LW at 0x101 -> ram_req_o never asserts, exc_valid_o=1 for one cycle, exc_cause_o=4, exc_tval_o=0x101, and stall_o lasts 1 cycle.
REQ-027 With LSU_TIMEOUT_EN defined and TIMEOUT_CYCLES=16, a `SW with ram_ack_i tied to 0 -> ram_req_o high for 16 cycles, then exc_cause_o=7.
REQ-028 DATA_WIDTH=64, `LWU at 0x0C with rdata 0xFFFFFFFF00000000 -> ram_be_o=8'hF0 and reg_wdata_o=0x00000000FFFFFFFF.
REQ-029 rst_i pulsed in the 2nd BUSY cycle of a `LW, followed by ram_ack_i=1 -> ram_req_o=0 immediately, and no reg_we_o or exc_valid_o follows.
